lcd_window_scanout: RTL
=======================

Name: lcd_window_scanout

Overview:
- Parametrised successor to the fixed 480x272 LCD timing-plus-window logic.
- Generates HSYNC/VSYNC/DEN from parameterised porches and counts pixels/lines.
- Produces pixel-replicated video-RAM read addresses for a square viewport, with per-frame scroll offsets.
- Delays all timing outputs to align with RAM read data. Sits between the PLL pixel clock domain and video_ram; the top level muxes `ram_data` with the background pattern using `in_win`.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_BACK, 43, back porch (includes pulse), pixels
- H_PULSE, 4, HSYNC pulse width, pixels
- H_FRONT, 8, front porch, pixels
- V_ACTIVE, 272, visible lines
- V_BACK, 12, back porch (includes pulse), lines
- V_PULSE, 4, VSYNC pulse width, lines
- V_FRONT, 8, front porch, lines
- WIN_X, 160, window left edge, absolute h count
- WIN_Y, 18, window top edge, absolute v count
- WIN_LOG2, 8, window side = 2**WIN_LOG2 screen pixels
- SCALE_LOG2, 2, each source pixel replicated 2**SCALE_LOG2 times in both axes
- RAM_LAT, 1, video RAM read latency in cycles (1..3)
- SYNC_POL, 0, active level of hsync/vsync
- Derived: SRC_LOG2 = WIN_LOG2 - SCALE_LOG2; ADDR_W = 2*SRC_LOG2; H_TOTAL = H_BACK + H_ACTIVE + H_FRONT; V_TOTAL = V_BACK + V_ACTIVE + V_FRONT

Ports:
- pixel_clk, in, 1, pixel clock
- rst, in, 1, asynchronous, active-low reset
- scroll_x, in, SRC_LOG2, horizontal scroll in source pixels; sampled at frame start
- scroll_y, in, SRC_LOG2, vertical scroll in source pixels; sampled at frame start
- ram_addr, out, ADDR_W, read address {row, col}
- ram_rd, out, 1, read enable (window pixel)
- ram_data, in, 8, RAM read data (pass-through)
- pix_data, out, 8, ram_data, aligned with outputs below
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- den, out, 1, data enable
- in_win, out, 1, current output pixel lies inside the window
- frame_start, out, 1, one-cycle pulse, first pixel of frame
- line_start, out, 1, one-cycle pulse, first pixel of each line

Behaviour:
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps, incrementing v_cnt. v_cnt runs 0..V_TOTAL-1 and wraps. Both are 16 bits. Reset value is 0.
- Stage 0 (counters) decode:
  - hs = h_cnt < H_PULSE
  - vs = v_cnt < V_PULSE
  - de = h_cnt in [H_BACK, H_BACK+H_ACTIVE) and v_cnt in [V_BACK, V_BACK+V_ACTIVE)
  - win = h_cnt in [WIN_X, WIN_X+2**WIN_LOG2) and v_cnt in [WIN_Y, WIN_Y+2**WIN_LOG2)
- Scroll shadow registers sx/sy load scroll_x/scroll_y when h_cnt==0 and v_cnt==0. Mid-frame changes have no effect until the next frame. Reset value is 0.
- Address generation, registered (1 cycle after stage 0):
  - col = ((h_cnt-WIN_X) >> SCALE_LOG2) + sx, mod 2**SRC_LOG2
  - row = ((v_cnt-WIN_Y) >> SCALE_LOG2) + sy, mod 2**SRC_LOG2
  - ram_rd = win
  - Outside the window, ram_addr holds its last value and ram_rd = 0.
- Output alignment: hsync, vsync, den, in_win, frame_start and line_start are delayed 1+RAM_LAT cycles from stage 0, so they coincide with ram_data for the same pixel. pix_data = ram_data (combinational).
- Sync polarity: hsync = hs XNOR SYNC_POL, i.e. driven low when active for SYNC_POL=0. vsync follows the same rule.
- Reset values:
  - all counters and pipeline registers = 0
  - den, in_win, frame_start, line_start, ram_rd = 0
  - ram_addr = 0
  - hsync and vsync at their inactive level
- Reset mid-frame: everything restarts from h_cnt=v_cnt=0. The first frame_start appears 1+RAM_LAT cycles after rst is released.
- Parameter checks (elaboration error if violated):
  - H_PULSE <= H_BACK; V_PULSE <= V_BACK
  - window fits inside the active area
  - SCALE_LOG2 < WIN_LOG2

Decomposition:
- Package lcd_timing_pkg holds:
  - the default 480x272 porch/pulse constants
  - a function computing H_TOTAL/V_TOTAL
  - a ceiling-log2 helper
- Sub-module lcd_delay_line (width, depth), used for the RAM_LAT alignment pipe.

Test Plan:
- Defaults, run 2 frames:
  - H_TOTAL = 531 and V_TOTAL = 292 cycles/lines between frame_start pulses (155052 cycles)
  - hsync low for 4 cycles per line
  - den high for 480x272 pixels per frame
- Window entry with sx=sy=0: at h_cnt=160, v_cnt=18, ram_addr=0 and ram_rd=1 one cycle later. At h_cnt=164, col=1. At v_cnt=22, row=1.
- Scroll: set scroll_x=63, scroll_y=5 mid-frame. Current frame addresses unchanged. Next frame's first window pixel has address {row=5, col=63}; 4 window pixels later, col wraps to 0.
- Alignment with RAM_LAT=2 and a model RAM returning data = address[7:0]: whenever in_win=1, pix_data equals the low byte of the address issued for that pixel, and den/hsync match stage-0 decode delayed by 3 cycles.
- Async reset asserted at h_cnt=300, v_cnt=100 (not on a clock edge): outputs go to reset values immediately. After release, frame_start pulses exactly 2 cycles later (RAM_LAT=1).
- SYNC_POL=1: hsync high for h_cnt<4 and low otherwise; the reset level is low.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared constants and helpers for the LCD scan-out blocks.
//   - Default 480x272 panel porch/pulse values (pixels and lines)
//   - lcd_total(): total period from back porch, active and front porch
//   - clog2_int(): ceiling log2, used for elaboration-time width checks
//   - timing_t: per-pixel timing flags carried down the alignment pipe
package lcd_timing_pkg;

  localparam int LCD_H_ACTIVE = 480;
  localparam int LCD_H_BACK   = 43;
  localparam int LCD_H_PULSE  = 4;
  localparam int LCD_H_FRONT  = 8;
  localparam int LCD_V_ACTIVE = 272;
  localparam int LCD_V_BACK   = 12;
  localparam int LCD_V_PULSE  = 4;
  localparam int LCD_V_FRONT  = 8;

  // Pixel and line counters are fixed at 16 bits.
  localparam int CNT_W = 16;

  typedef struct packed {
    logic hs;   // sync pulse active (before polarity is applied)
    logic vs;
    logic de;   // visible area
    logic win;  // inside the viewport
    logic fs;   // first pixel of frame
    logic ls;   // first pixel of line
  } timing_t;

  function automatic int lcd_total(input int back, input int active, input int front);
    return back + active + front;
  endfunction

  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// Fixed-depth shift register used to align timing flags with RAM read data.
//   pixel_clk : clock
//   rst       : asynchronous active-low reset, clears every stage
//   d         : input word
//   q         : d delayed by DEPTH cycles
module lcd_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/lcd_window_scanout.sv
// LCD timing generator with a scaled, scrollable square viewport.
//   pixel_clk, rst       : pixel clock, asynchronous active-low reset
//   scroll_x, scroll_y   : scroll in source pixels, taken at frame start
//   ram_addr, ram_rd     : video RAM read address {row, col} and enable
//   ram_data, pix_data   : RAM read data, passed straight through
//   hsync, vsync, den    : panel timing, aligned with pix_data
//   in_win               : aligned pixel lies inside the viewport
//   frame_start, line_start : one-cycle pulses on the first pixel of frame/line
// Stage 0 is the h/v counter; stage 1 registers the RAM address; the timing
// flags then travel through RAM_LAT more stages so they meet ram_data.
module lcd_window_scanout
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE   = LCD_H_ACTIVE,
  parameter int H_BACK     = LCD_H_BACK,
  parameter int H_PULSE    = LCD_H_PULSE,
  parameter int H_FRONT    = LCD_H_FRONT,
  parameter int V_ACTIVE   = LCD_V_ACTIVE,
  parameter int V_BACK     = LCD_V_BACK,
  parameter int V_PULSE    = LCD_V_PULSE,
  parameter int V_FRONT    = LCD_V_FRONT,
  parameter int WIN_X      = 160,
  parameter int WIN_Y      = 18,
  parameter int WIN_LOG2   = 8,
  parameter int SCALE_LOG2 = 2,
  parameter int RAM_LAT    = 1,
  parameter int SYNC_POL   = 0
) (
  input  logic                                  pixel_clk,
  input  logic                                  rst,
  input  logic [WIN_LOG2-SCALE_LOG2-1:0]        scroll_x,
  input  logic [WIN_LOG2-SCALE_LOG2-1:0]        scroll_y,
  output logic [2*(WIN_LOG2-SCALE_LOG2)-1:0]    ram_addr,
  output logic                                  ram_rd,
  input  logic [7:0]                            ram_data,
  output logic [7:0]                            pix_data,
  output logic                                  hsync,
  output logic                                  vsync,
  output logic                                  den,
  output logic                                  in_win,
  output logic                                  frame_start,
  output logic                                  line_start
);

  localparam int SRC_LOG2 = WIN_LOG2 - SCALE_LOG2;
  localparam int H_TOTAL  = lcd_total(H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL  = lcd_total(V_BACK, V_ACTIVE, V_FRONT);
  localparam int WIN_SIDE = 1 << WIN_LOG2;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_PULSE_C = CNT_W'(H_PULSE);
  localparam logic [CNT_W-1:0] V_PULSE_C = CNT_W'(V_PULSE);
  localparam logic [CNT_W-1:0] H_DE_BEG = CNT_W'(H_BACK);
  localparam logic [CNT_W-1:0] H_DE_END = CNT_W'(H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_DE_BEG = CNT_W'(V_BACK);
  localparam logic [CNT_W-1:0] V_DE_END = CNT_W'(V_BACK + V_ACTIVE);
  localparam logic [CNT_W-1:0] H_WN_BEG = CNT_W'(WIN_X);
  localparam logic [CNT_W-1:0] H_WN_END = CNT_W'(WIN_X + WIN_SIDE);
  localparam logic [CNT_W-1:0] V_WN_BEG = CNT_W'(WIN_Y);
  localparam logic [CNT_W-1:0] V_WN_END = CNT_W'(WIN_Y + WIN_SIDE);
  localparam logic             SYNC_ACT = (SYNC_POL != 0);

  // Elaboration-time parameter checks.
  if (H_PULSE > H_BACK || V_PULSE > V_BACK) begin : g_bad_pulse
    $error("sync pulse longer than back porch");
  end
  if (WIN_X < H_BACK || WIN_X + WIN_SIDE > H_BACK + H_ACTIVE ||
      WIN_Y < V_BACK || WIN_Y + WIN_SIDE > V_BACK + V_ACTIVE) begin : g_bad_win
    $error("window does not fit inside the active area");
  end
  if (SCALE_LOG2 >= WIN_LOG2) begin : g_bad_scale
    $error("SCALE_LOG2 must be smaller than WIN_LOG2");
  end
  if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_lat
    $error("RAM_LAT must be 1..3");
  end
  if (clog2_int(H_TOTAL) > CNT_W || clog2_int(V_TOTAL) > CNT_W) begin : g_bad_total
    $error("timing totals exceed the 16-bit counters");
  end

  logic [CNT_W-1:0]    h_cnt, v_cnt;
  logic [SRC_LOG2-1:0] sx, sy;
  logic [SRC_LOG2-1:0] col, row;
  timing_t             s0, s1, s_out;

  // Stage 0: free-running raster counters.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    s0     = '0;
    s0.hs  = h_cnt < H_PULSE_C;
    s0.vs  = v_cnt < V_PULSE_C;
    s0.de  = (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END) &&
             (v_cnt >= V_DE_BEG) && (v_cnt < V_DE_END);
    s0.win = (h_cnt >= H_WN_BEG) && (h_cnt < H_WN_END) &&
             (v_cnt >= V_WN_BEG) && (v_cnt < V_WN_END);
    s0.fs  = (h_cnt == '0) && (v_cnt == '0);
    s0.ls  = (h_cnt == '0);
  end

  // Source coordinates: screen offset divided by the replication factor,
  // plus scroll; the truncation to SRC_LOG2 bits gives the wrap-around.
  // Outside the window the offset is garbage, but it is never loaded.
  assign col = SRC_LOG2'((h_cnt - H_WN_BEG) >> SCALE_LOG2) + sx;
  assign row = SRC_LOG2'((v_cnt - V_WN_BEG) >> SCALE_LOG2) + sy;

  // Stage 1: address register, scroll shadows, first timing stage.
  // Scroll is captured on the frame's first pixel so a frame never tears.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      s1       <= '0;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
      sx       <= '0;
      sy       <= '0;
    end else begin
      s1     <= s0;
      ram_rd <= s0.win;
      if (s0.win) ram_addr <= {row, col};
      if (s0.fs) begin
        sx <= scroll_x;
        sy <= scroll_y;
      end
    end
  end

  lcd_delay_line #(
    .WIDTH ($bits(timing_t)),
    .DEPTH (RAM_LAT)
  ) u_align (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .d         (s1),
    .q         (s_out)
  );

  // All-zero pipeline state maps to the inactive sync level.
  assign hsync       = ~(s_out.hs ^ SYNC_ACT);
  assign vsync       = ~(s_out.vs ^ SYNC_ACT);
  assign den         = s_out.de;
  assign in_win      = s_out.win;
  assign frame_start = s_out.fs;
  assign line_start  = s_out.ls;
  assign pix_data    = ram_data;

endmodule
